// File: rtl/i2s_playback.sv
// i2s_playback: stereo pair FIFO feeding an I2S transmitter, 64 bit clocks per frame, WS leads MSB by one bit.
// Latency: a stored pair goes out in the next frame; ws/sd/underrun register on the bit-clock falling edge.
// Backpressure: sample_ready drops while the FIFO is full; empty frames send zeros, or with
//   I2S_PLAYBACK_REPEAT_EN defined, repeat the last popped pair.
module i2s_playback #(
   parameter int DATA_SIZE    = 24,
   parameter int CLK_FREQ     = 100_000_000,
   parameter int I2S_CLK_FREQ = 1_500_000,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] sample_left,
   input  logic [DATA_SIZE-1:0] sample_right,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 i2s_clk,
   output logic                 i2s_ws,
   output logic                 i2s_sd,
   output logic                 underrun
);

   localparam int CLK_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int PAIR_W  = 2 * DATA_SIZE;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [6:0]       LEFT_END  = 7'(DATA_SIZE);
   localparam logic [6:0]       RIGHT_END = 7'(32 + DATA_SIZE);

   // Pair FIFO: left in the upper half, right in the lower half, so a pair never splits.
   logic [PAIR_W-1:0]    mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic                 ready_q, ready_d;

   // Bit-clock generation and serializer state.
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 sclk_q, sclk_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [5:0]           cnt_next;
   logic                 ws_q, ws_d;
   logic                 sd_q, sd_d;
   logic                 under_q, under_d;
   logic [DATA_SIZE-1:0] left_sr_q, left_sr_d;
   logic [DATA_SIZE-1:0] right_sr_q, right_sr_d;

   logic [DATA_SIZE-1:0] head_l, head_r;
   logic [DATA_SIZE-1:0] fill_l, fill_r;
   logic [DATA_SIZE-1:0] load_l, load_r;
   logic                 fall, empty, push, pop_point, pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign push      = sample_valid && ready_q;
   assign fall      = (div_q == DIV_LAST) && sclk_q;
   // The pop happens on the fall that wraps bit_cnt to 0; a same-cycle push is not visible yet.
   assign pop_point = fall && (bit_cnt_q == 6'd63);
   assign pop       = pop_point && !empty;
   assign cnt_next  = bit_cnt_q + 6'd1;
   assign {head_l, head_r} = mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef I2S_PLAYBACK_REPEAT_EN
   logic [DATA_SIZE-1:0] hold_l_q, hold_r_q;

   // Remember the last pair taken from the FIFO so an empty frame can replay it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_l_q <= '0;
         hold_r_q <= '0;
      end else if (pop) begin
         hold_l_q <= head_l;
         hold_r_q <= head_r;
      end
   end

   assign fill_l = hold_l_q;
   assign fill_r = hold_r_q;
`else
   assign fill_l = '0;
   assign fill_r = '0;
`endif

   assign load_l = pop ? head_l : fill_l;
   assign load_r = pop ? head_r : fill_r;

   // Next-state: divider, FIFO pointers, and frame serialization on bit-clock fall events.
   always_comb begin
      div_d      = div_q;
      sclk_d     = sclk_q;
      bit_cnt_d  = bit_cnt_q;
      ws_d       = ws_q;
      sd_d       = sd_q;
      left_sr_d  = left_sr_q;
      right_sr_d = right_sr_q;
      under_d    = 1'b0;

      wr_ptr_d = push ? (wr_ptr_q + CNT_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + CNT_W'(1)) : rd_ptr_q;
      ready_d  = ((wr_ptr_d - rd_ptr_d) != FIFO_FULL);

      if (div_q == DIV_LAST) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      if (fall) begin
         bit_cnt_d = cnt_next;
         ws_d      = (cnt_next >= 6'd31) && (cnt_next <= 6'd62);
         sd_d      = 1'b0;
         if (cnt_next == 6'd0) begin
            sd_d       = load_l[DATA_SIZE-1];
            left_sr_d  = load_l << 1;
            right_sr_d = load_r;
            under_d    = empty;
         end else if ({1'b0, cnt_next} < LEFT_END) begin
            sd_d      = left_sr_q[DATA_SIZE-1];
            left_sr_d = left_sr_q << 1;
         end else if (({1'b0, cnt_next} >= 7'd32) && ({1'b0, cnt_next} < RIGHT_END)) begin
            sd_d       = right_sr_q[DATA_SIZE-1];
            right_sr_d = right_sr_q << 1;
         end
      end
   end

   // State registers; reset aborts any frame in flight and empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q      <= '0;
         sclk_q     <= 1'b0;
         bit_cnt_q  <= 6'd63;
         ws_q       <= 1'b0;
         sd_q       <= 1'b0;
         under_q    <= 1'b0;
         left_sr_q  <= '0;
         right_sr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         bit_cnt_q  <= bit_cnt_d;
         ws_q       <= ws_d;
         sd_q       <= sd_d;
         under_q    <= under_d;
         left_sr_q  <= left_sr_d;
         right_sr_q <= right_sr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ready_q    <= ready_d;
      end
   end

   // FIFO storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= {sample_left, sample_right};
      end
   end

   assign sample_ready = ready_q;
   assign i2s_clk      = sclk_q;
   assign i2s_ws       = ws_q;
   assign i2s_sd       = sd_q;
   assign underrun     = under_q;

endmodule
